// File: rtl/jt9346_ctrl_pkg.sv
// Shared definitions for the 93C46 serial master: host op codes, wire opcodes
// and one-hot controller states.
package jt9346_ctrl_pkg;

    localparam logic [2:0] OP_READ  = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_ERASE = 3'd2;
    localparam logic [2:0] OP_EWEN  = 3'd3;
    localparam logic [2:0] OP_EWDS  = 3'd4;
    localparam logic [2:0] OP_ERAL  = 3'd5;
    localparam logic [2:0] OP_WRAL  = 3'd6;
    localparam logic [2:0] OP_ILL   = 3'd7;

    localparam logic [1:0] OPC_READ  = 2'b10;
    localparam logic [1:0] OPC_WRITE = 2'b01;
    localparam logic [1:0] OPC_ERASE = 2'b11;
    localparam logic [1:0] OPC_EXT   = 2'b00;

    // Extended ops carry their sub-op in the two address MSBs
    localparam logic [1:0] SUB_EWEN = 2'b11;
    localparam logic [1:0] SUB_EWDS = 2'b00;
    localparam logic [1:0] SUB_ERAL = 2'b10;
    localparam logic [1:0] SUB_WRAL = 2'b01;

    typedef enum logic [6:0] {
        ST_IDLE       = 7'b0000001,
        ST_SETUP      = 7'b0000010,
        ST_SHIFT_OUT  = 7'b0000100,
        ST_SHIFT_IN   = 7'b0001000,
        ST_DESEL_POLL = 7'b0010000,
        ST_POLL       = 7'b0100000,
        ST_DESEL_END  = 7'b1000000
    } state_t;

    function automatic logic [1:0] op_code(input logic [2:0] op);
        case (op)
            OP_READ:  return OPC_READ;
            OP_WRITE: return OPC_WRITE;
            OP_ERASE: return OPC_ERASE;
            default:  return OPC_EXT;
        endcase
    endfunction

    function automatic logic [1:0] sub_code(input logic [2:0] op);
        case (op)
            OP_EWEN: return SUB_EWEN;
            OP_ERAL: return SUB_ERAL;
            OP_WRAL: return SUB_WRAL;
            default: return SUB_EWDS;
        endcase
    endfunction

endpackage

// File: rtl/jt9346_ctrl_tick.sv
// Half-period divider for sclk: strobes once every CLKDIV clocks while enabled,
// split into rise/fall strobes according to the current sclk level.
module jt9346_ctrl_tick #(
    parameter int CLKDIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic lvl,
    output logic tick,
    output logic rise,
    output logic fall
);
    localparam int CW = (CLKDIV > 2) ? $clog2(CLKDIV) : 2;

    logic [CW-1:0] cnt;

    assign tick = en && !clr && (cnt == CW'(CLKDIV - 1));
    assign rise = tick && !lvl;
    assign fall = tick && lvl;

    always_ff @(posedge clk) begin
        if (rst || clr || !en || tick) cnt <= '0;
        else                           cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/jt9346_ctrl.sv
// Register-interface master for a 93C46-style serial EEPROM: serialises one
// command, captures read data and polls ready after programming ops.
module jt9346_ctrl
    import jt9346_ctrl_pkg::*;
#(
    parameter int AW     = 6,
    parameter int DW     = 16,
    parameter int CLKDIV = 4,
    parameter int TOUT   = 65535
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          sclk,
    output logic          sdi,
    output logic          scs,
    input  logic          sdo
);
    localparam int HW = 3 + AW;
    localparam int SW = HW + DW;
    localparam int BW = $clog2(SW + 1);
    localparam int CW = $clog2(TOUT + 2*CLKDIV + 1);

    state_t        state, state_nxt;
    logic [2:0]    op_q;
    logic [SW-1:0] sh;
    logic [BW-1:0] bcnt;
    logic [CW-1:0] cnt;
    logic          sclk_q, tout_flag, ill_pend;
    logic          accept, shifting, tick, rise, fall;
    logic          has_data, last_out, last_in, gap_done, poll_to;

    assign accept   = cmd_valid && cmd_ready;
    assign shifting = (state == ST_SHIFT_OUT) || (state == ST_SHIFT_IN);
    assign has_data = (op_q == OP_WRITE) || (op_q == OP_WRAL);
    assign last_out = bcnt == (has_data ? BW'(SW - 1) : BW'(HW - 1));
    assign last_in  = bcnt == BW'(DW - 1);
    assign gap_done = cnt == CW'(2*CLKDIV - 1);
    assign poll_to  = cnt == CW'(TOUT - 1);
    assign sclk     = sclk_q;

    jt9346_ctrl_tick #(.CLKDIV(CLKDIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   ((state == ST_SETUP) || shifting),
        .clr  (accept),
        .lvl  (sclk_q),
        .tick (tick),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:       if (accept && cmd_op != OP_ILL) state_nxt = ST_SETUP;
            ST_SETUP:      if (tick) state_nxt = ST_SHIFT_OUT;
            ST_SHIFT_OUT:  if (fall && last_out) begin
                               if (op_q == OP_READ)                           state_nxt = ST_SHIFT_IN;
                               else if (op_q == OP_EWEN || op_q == OP_EWDS)   state_nxt = ST_DESEL_END;
                               else                                           state_nxt = ST_DESEL_POLL;
                           end
            ST_SHIFT_IN:   if (fall && last_in) state_nxt = ST_DESEL_END;
            ST_DESEL_POLL: if (gap_done) state_nxt = ST_POLL;
            ST_POLL:       if (sdo || poll_to) state_nxt = ST_DESEL_END;
            ST_DESEL_END:  if (gap_done) state_nxt = ST_IDLE;
            default:       state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        scs       = 1'b0;
        sdi       = 1'b0;
        unique case (state)
            ST_IDLE:               cmd_ready = !ill_pend;
            ST_SETUP, ST_SHIFT_OUT: begin
                scs = 1'b1;
                sdi = sh[SW-1];
            end
            ST_SHIFT_IN, ST_POLL:  scs = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            sh        <= '0;
            bcnt      <= '0;
            cnt       <= '0;
            sclk_q    <= 1'b0;
            tout_flag <= 1'b0;
            ill_pend  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            if (ill_pend) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                ill_pend  <= 1'b0;
            end
            if (accept) begin
                op_q      <= cmd_op;
                tout_flag <= 1'b0;
                ill_pend  <= (cmd_op == OP_ILL);
                sh        <= {1'b1, op_code(cmd_op),
                              (cmd_op <= OP_ERASE) ? cmd_addr : {sub_code(cmd_op), {(AW-2){1'b0}}},
                              cmd_data};
            end
            if (shifting) begin
                if (rise)      sclk_q <= 1'b1;
                else if (fall) sclk_q <= 1'b0;
            end
            // sdi moves only with the falling strobe, giving a half period of setup
            if (state == ST_SHIFT_OUT && fall) sh <= sh << 1;
            if (state == ST_SHIFT_IN && fall)  rsp_data <= {rsp_data[DW-2:0], sdo};

            if (state_nxt != state) bcnt <= '0;
            else if (fall)          bcnt <= bcnt + 1'b1;

            if (state_nxt != state)
                cnt <= '0;
            else if (state inside {ST_DESEL_POLL, ST_POLL, ST_DESEL_END})
                cnt <= cnt + 1'b1;

            if (state == ST_POLL && !sdo && poll_to) tout_flag <= 1'b1;
            if (state == ST_DESEL_END && gap_done) begin
                rsp_valid <= 1'b1;
                rsp_err   <= tout_flag;
            end
        end
    end

endmodule
